// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO: MULTU/MULT/DIVU/DIV in 33 cycles.
// Operands are made unsigned on start; the latched signs are reapplied in a single fix-up cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e      r_state, w_state_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    logic        r_is_div, w_is_div_nxt;
    logic [31:0] r_b, w_b_nxt;
    // Shared datapath: multiply {upper33, multiplier}; divide {rem33, quot32}
    logic [64:0] r_acc, w_acc_nxt;
    logic [31:0] r_a_raw, w_a_raw_nxt;
    logic        r_neg_q, w_neg_q_nxt;
    logic        r_neg_r, w_neg_r_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_dbz, w_dbz_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    logic [31:0] w_a_abs, w_b_abs;
    logic [32:0] w_mul_sum, w_mul_hi;
    logic [64:0] w_mul_step;
    logic [32:0] w_rem_sh;
    logic [33:0] w_diff;
    logic [64:0] w_div_step;
    logic [63:0] w_prod;
    logic [31:0] w_quot, w_rem;

    assign w_a_abs = (op[0] && a[31]) ? (~a + 32'd1) : a;
    assign w_b_abs = (op[0] && b[31]) ? (~b + 32'd1) : b;

    assign w_mul_sum  = r_acc[64:32] + {1'b0, r_b};
    assign w_mul_hi   = r_acc[0] ? w_mul_sum : r_acc[64:32];
    assign w_mul_step = {1'b0, w_mul_hi, r_acc[31:1]};

    assign w_rem_sh   = r_acc[63:31];
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_div_step = w_diff[33] ? {w_rem_sh, r_acc[30:0], 1'b0}
                                   : {w_diff[32:0], r_acc[30:0], 1'b1};

    assign w_prod = r_neg_q ? (~r_acc[63:0] + 64'd1) : r_acc[63:0];
    assign w_quot = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_is_div_nxt = r_is_div;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_a_raw_nxt  = r_a_raw;
        w_neg_q_nxt  = r_neg_q;
        w_neg_r_nxt  = r_neg_r;
        w_done_nxt   = 1'b0;
        w_dbz_nxt    = r_dbz;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;

        unique case (r_state)
            StIdle: begin
                if (hi_we) w_hi_nxt = wdata;
                if (lo_we) w_lo_nxt = wdata;
                if (start) begin
                    w_state_nxt  = StRun;
                    w_cnt_nxt    = 5'd0;
                    w_is_div_nxt = op[1];
                    w_b_nxt      = w_b_abs;
                    w_acc_nxt    = {33'd0, w_a_abs};
                    w_a_raw_nxt  = a;
                    w_neg_q_nxt  = op[0] & (a[31] ^ b[31]);
                    w_neg_r_nxt  = op[0] & op[1] & a[31];
                    w_dbz_nxt    = op[1] & (b == 32'd0);
                end
            end
            StRun: begin
                w_acc_nxt = r_is_div ? w_div_step : w_mul_step;
                w_cnt_nxt = r_cnt + 5'd1;
                if (r_cnt == 5'd31) w_state_nxt = StFix;
            end
            StFix: begin
                w_state_nxt = StIdle;
                w_done_nxt  = 1'b1;
                if (!r_is_div) begin
                    w_hi_nxt = w_prod[63:32];
                    w_lo_nxt = w_prod[31:0];
                end else if (r_dbz) begin
                    // Divide by zero bypasses the algorithm result
                    w_hi_nxt = r_a_raw;
                    w_lo_nxt = 32'hFFFF_FFFF;
                end else begin
                    w_hi_nxt = w_rem;
                    w_lo_nxt = w_quot;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_b      <= 32'd0;
            r_acc    <= 65'd0;
            r_a_raw  <= 32'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_is_div <= w_is_div_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_a_raw  <= w_a_raw_nxt;
            r_neg_q  <= w_neg_q_nxt;
            r_neg_r  <= w_neg_r_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_dbz    <= w_dbz_nxt;
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned results, divide-by-zero,
// MTHI/MTLO gating, ignored restart and mid-operation reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    int n_cyc;
    int busy_cnt;
    int done_cnt;
    logic [31:0] cap_hi, cap_lo;

    muldiv_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch an op and wait (bounded) for done; records latency and busy length
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        n_cyc = 0;
        do begin
            tick();
            n_cyc++;
            if (busy) busy_cnt++;
        end while (!done && n_cyc < 60);
    endtask

    initial begin
        #12;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        rst_n = 1'b1;
        tick();

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_latency", n_cyc, 33);
        chk("multu_busy_len", busy_cnt, 33);
        chk("multu_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        chk("multu_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);
        chk("multu_busy_at_done", {63'd0, busy}, 64'd0);
        tick();
        chk("multu_done_one_pulse", {63'd0, done}, 64'd0);

        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);

        run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

        run_op(2'b11, 32'h0000_0007, 32'hFFFF_FFFE);
        chk("div_negb_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
        chk("div_negb_hi", {32'd0, hi}, 64'h0000_0000_0000_0001);

        run_op(2'b10, 32'h0000_0064, 32'h0000_0000);
        chk("divu_dbz_latency", n_cyc, 33);
        chk("divu_dbz_hi", {32'd0, hi}, 64'h0000_0000_0000_0064);
        chk("divu_dbz_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
        chk("divu_dbz_flag", {63'd0, div_by_zero}, 64'd1);

        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        chk("div_ovf_hi", {32'd0, hi}, 64'd0);
        chk("div_ovf_flag", {63'd0, div_by_zero}, 64'd0);

        // MTHI in idle, then MTLO attempted during a run
        tick();
        hi_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        chk("mthi_idle", {32'd0, hi}, 64'h0000_0000_1234_5678);
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        lo_we = 1'b0;
        chk("mtlo_ignored_busy", {32'd0, lo}, 64'h0000_0000_8000_0000);
        chk("hi_stable_run", {32'd0, hi}, 64'h0000_0000_1234_5678);
        n_cyc = 0;
        while (!done && n_cyc < 60) begin
            tick();
            n_cyc++;
        end
        chk("mul23_done_seen", {63'd0, done}, 64'd1);
        chk("mul23_hi", {32'd0, hi}, 64'd0);
        chk("mul23_lo", {32'd0, lo}, 64'd6);

        // Restart while busy must be ignored
        tick();
        op = 2'b00; a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        cap_hi = 32'hX; cap_lo = 32'hX;
        for (int i = 1; i <= 50; i++) begin
            if (i == 10) begin
                a = 32'd9; b = 32'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                done_cnt++;
                cap_hi = hi;
                cap_lo = lo;
            end
        end
        chk("restart_one_done", done_cnt, 1);
        chk("restart_hi", {32'd0, cap_hi}, 64'd0);
        chk("restart_lo", {32'd0, cap_lo}, 64'd35);
        chk("restart_idle_after", {63'd0, busy}, 64'd0);

        // Reset in the middle of a divide
        op = 2'b11; a = 32'd1000; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            tick();
            if (done) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);

        run_op(2'b10, 32'd1000, 32'd7);
        chk("post_rst_latency", n_cyc, 33);
        chk("post_rst_lo", {32'd0, lo}, 64'd142);
        chk("post_rst_hi", {32'd0, hi}, 64'd6);

        // Back-to-back start issued in the done cycle
        run_op(2'b10, 32'hFFFF_FFFF, 32'h0000_0010);
        chk("b2b_latency", n_cyc, 33);
        chk("b2b_lo", {32'd0, lo}, 64'h0000_0000_0FFF_FFFF);
        chk("b2b_hi", {32'd0, hi}, 64'h0000_0000_0000_000F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
